// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encoding for the instruction/data memory sequencer
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_INSTR = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - runs the pending data access then the instruction fetch over one
// memory bus, and presents both results together for one CPU pipeline advance
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_W-1:0]     i_addr_i,
    input  logic [ADDR_W-1:0]     i_addr_d,
    input  logic [DATA_W/8-1:0]   i_we_d,
    input  logic                  i_rd_d,
    input  logic [DATA_W-1:0]     i_wdata_d,
    input  logic                  i_cpu_ce,
    output logic                  o_valid_i,
    output logic                  o_valid_d,
    output logic [DATA_W-1:0]     o_data_i,
    output logic [DATA_W-1:0]     o_data_d,
    output logic                  o_mem_req,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W/8-1:0]   o_mem_we,
    output logic [DATA_W-1:0]     o_mem_wdata,
    input  logic [DATA_W-1:0]     i_mem_rdata,
    input  logic                  i_mem_ack
);

    localparam int BE_W = DATA_W / 8;

    state_t state;
    state_t state_nxt;
    logic   req_nxt;
    logic   valid_nxt;
    logic   is_read;
    logic   data_access;
    logic   data_write;

    assign data_write  = |i_we_d;
    assign data_access = i_rd_d | data_write;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = data_access ? ST_DATA : ST_INSTR;
            ST_DATA:  if (i_mem_ack) state_nxt = ST_INSTR;
            ST_INSTR: if (i_mem_ack) state_nxt = ST_DONE;
            ST_DONE:  if (i_cpu_ce)  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Request and valids are decoded from the next state and then registered,
    // so neither has a combinational path from any input.
    always_comb begin
        req_nxt   = (state_nxt == ST_DATA) || (state_nxt == ST_INSTR);
        valid_nxt = (state_nxt == ST_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_mem_req   <= 1'b0;
            o_valid_i   <= 1'b0;
            o_valid_d   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_we    <= '0;
            o_mem_wdata <= '0;
            o_data_i    <= '0;
            o_data_d    <= '0;
            is_read     <= 1'b0;
        end else begin
            o_mem_req <= req_nxt;
            o_valid_i <= valid_nxt;
            o_valid_d <= valid_nxt;
            case (state)
                ST_IDLE: begin
                    if (data_access) begin
                        o_mem_addr  <= i_addr_d;
                        o_mem_we    <= i_we_d;
                        o_mem_wdata <= i_wdata_d;
                        // A simultaneous write wins over the read.
                        is_read     <= !data_write;
                    end else begin
                        o_mem_addr  <= i_addr_i;
                        o_mem_we    <= '0;
                        is_read     <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (i_mem_ack) begin
                        if (is_read) begin
                            o_data_d <= i_mem_rdata;
                        end
                        o_mem_addr <= i_addr_i;
                        o_mem_we   <= {BE_W{1'b0}};
                    end
                end
                ST_INSTR: begin
                    if (i_mem_ack) begin
                        o_data_i <= i_mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    logic        i_clk;
    logic        i_rst;
    logic [31:0] i_addr_i;
    logic [31:0] i_addr_d;
    logic [3:0]  i_we_d;
    logic        i_rd_d;
    logic [31:0] i_wdata_d;
    logic        i_cpu_ce;
    logic        o_valid_i;
    logic        o_valid_d;
    logic [31:0] o_data_i;
    logic [31:0] o_data_d;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_we;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_ack;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_addr_i(i_addr_i), .i_addr_d(i_addr_d), .i_we_d(i_we_d),
        .i_rd_d(i_rd_d), .i_wdata_d(i_wdata_d), .i_cpu_ce(i_cpu_ce),
        .o_valid_i(o_valid_i), .o_valid_d(o_valid_d),
        .o_data_i(o_data_i), .o_data_d(o_data_d),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        bit          chk_w;
    } mem_txn_t;

    typedef struct {
        logic [31:0] di;
        logic [31:0] dd;
    } res_t;

    mem_txn_t exp_mem[$];
    res_t     exp_res[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_mem(input logic [31:0] a, input logic [3:0] we,
                            input logic [31:0] wd, input bit cw);
        mem_txn_t t;
        t.addr = a; t.we = we; t.wdata = wd; t.chk_w = cw;
        exp_mem.push_back(t);
    endtask

    task automatic push_res(input logic [31:0] di, input logic [31:0] dd);
        res_t r;
        r.di = di; r.dd = dd;
        exp_res.push_back(r);
    endtask

    task automatic wait_req();
        mem_txn_t t;
        int n = 0;
        while (!o_mem_req && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        chk("req_seen", o_mem_req, 1);
        chk("mem_sb_nonempty", exp_mem.size() != 0, 1);
        if (exp_mem.size() != 0) begin
            t = exp_mem.pop_front();
            chk("mem_addr", o_mem_addr, t.addr);
            chk("mem_we", o_mem_we, t.we);
            if (t.chk_w) chk("mem_wdata", o_mem_wdata, t.wdata);
        end
    endtask

    task automatic give_ack(input logic [31:0] rdata, input int waits);
        for (int i = 0; i < waits; i++) begin
            i_mem_ack = 1'b0;
            @(negedge i_clk);
            chk("req_held_wait", o_mem_req, 1);
        end
        i_mem_rdata = rdata;
        i_mem_ack   = 1'b1;
        @(negedge i_clk);
        i_mem_ack   = 1'b0;
        i_mem_rdata = 32'h0BAD0BAD;
    endtask

    task automatic check_done(input int exp_cycles, input int stall);
        res_t r;
        chk("valid_i_done", o_valid_i, 1);
        chk("valid_d_done", o_valid_d, 1);
        chk("req_low_done", o_mem_req, 0);
        chk("latency", cyc - t0, exp_cycles);
        chk("res_sb_nonempty", exp_res.size() != 0, 1);
        if (exp_res.size() != 0) begin
            r = exp_res.pop_front();
            chk("data_i", o_data_i, r.di);
            chk("data_d", o_data_d, r.dd);
        end
        if (stall > 0) begin
            int reqs = 0;
            i_cpu_ce = 1'b0;
            for (int i = 0; i < stall; i++) begin
                @(negedge i_clk);
                if (o_mem_req) reqs++;
                chk("stall_valid_i", o_valid_i, 1);
                chk("stall_valid_d", o_valid_d, 1);
            end
            chk("stall_req_cycles", reqs, 0);
            i_cpu_ce = 1'b1;
        end
        @(negedge i_clk);
        chk("valid_i_drop", o_valid_i, 0);
        chk("valid_d_drop", o_valid_d, 0);
        chk("req_idle", o_mem_req, 0);
    endtask

    task automatic set_cpu(input logic [31:0] ai, input logic [31:0] ad, input logic rd,
                           input logic [3:0] we, input logic [31:0] wd);
        i_addr_i = ai; i_addr_d = ad; i_rd_d = rd; i_we_d = we; i_wdata_d = wd;
        t0 = cyc;
    endtask

    initial begin
        i_rst = 1'b1; i_cpu_ce = 1'b1; i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
        i_addr_i = '0; i_addr_d = '0; i_rd_d = 1'b0; i_we_d = '0; i_wdata_d = '0;
        repeat (2) @(negedge i_clk);
        chk("rst_valid_i", o_valid_i, 0);
        chk("rst_valid_d", o_valid_d, 0);
        chk("rst_req", o_mem_req, 0);
        chk("rst_addr", o_mem_addr, 0);
        chk("rst_we", o_mem_we, 0);
        chk("rst_wdata", o_mem_wdata, 0);
        chk("rst_data_i", o_data_i, 0);
        chk("rst_data_d", o_data_d, 0);

        // zero-wait fetch, no data access
        i_rst = 1'b0;
        set_cpu(32'h100, 32'h0, 1'b0, 4'b0000, 32'h0);
        push_mem(32'h100, 4'b0000, 32'h0, 1'b0);
        push_res(32'h00000013, 32'h0);
        wait_req();
        give_ack(32'h00000013, 0);
        check_done(2, 0);

        // load, zero-wait data then fetch with 2 wait states
        set_cpu(32'h104, 32'h2000, 1'b1, 4'b0000, 32'h0);
        push_mem(32'h2000, 4'b0000, 32'h0, 1'b0);
        push_mem(32'h104, 4'b0000, 32'h0, 1'b0);
        push_res(32'h00402283, 32'hDEADBEEF);
        wait_req();
        give_ack(32'hDEADBEEF, 0);
        wait_req();
        give_ack(32'h00402283, 2);
        check_done(5, 0);

        // byte store with a 5-cycle ALU stall in DONE
        set_cpu(32'h108, 32'h2002, 1'b0, 4'b0100, 32'h00AB0000);
        push_mem(32'h2002, 4'b0100, 32'h00AB0000, 1'b1);
        push_mem(32'h108, 4'b0000, 32'h0, 1'b0);
        push_res(32'h00B10123, 32'hDEADBEEF);
        wait_req();
        give_ack(32'hFFFFFFFF, 0);
        wait_req();
        give_ack(32'h00B10123, 0);
        check_done(3, 5);

        // read and write together: the write wins, one wait state on each access
        set_cpu(32'h10C, 32'h2010, 1'b1, 4'b0011, 32'h00001234);
        push_mem(32'h2010, 4'b0011, 32'h00001234, 1'b1);
        push_mem(32'h10C, 4'b0000, 32'h0, 1'b0);
        push_res(32'h00C00513, 32'hDEADBEEF);
        wait_req();
        give_ack(32'h77777777, 1);
        wait_req();
        give_ack(32'h00C00513, 1);
        check_done(5, 0);

        // reset while a data read is pending, then a stale ack
        set_cpu(32'h300, 32'h3000, 1'b1, 4'b0000, 32'h0);
        push_mem(32'h3000, 4'b0000, 32'h0, 1'b0);
        wait_req();
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("mid_rst_req", o_mem_req, 0);
        chk("mid_rst_addr", o_mem_addr, 0);
        chk("mid_rst_valid_i", o_valid_i, 0);
        chk("mid_rst_data_i", o_data_i, 0);
        chk("mid_rst_data_d", o_data_d, 0);
        i_rst = 1'b0;
        set_cpu(32'h300, 32'h0, 1'b0, 4'b0000, 32'h0);
        i_mem_rdata = 32'h55555555;
        i_mem_ack   = 1'b1;
        push_mem(32'h300, 4'b0000, 32'h0, 1'b0);
        push_res(32'h00000093, 32'h0);
        @(negedge i_clk);
        i_mem_ack = 1'b0;
        chk("stale_ack_data_d", o_data_d, 0);
        chk("stale_ack_data_i", o_data_i, 0);
        wait_req();
        give_ack(32'h00000093, 0);
        check_done(2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
